// File: rtl/fetch_pkg.sv
// Shared state encoding and default widths for the fetch sequencer.
// Pure definitions: no logic, no latency, no flow control.
package fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Architectural NOP; also the reset content of InstrF.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SQUASH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clr wins over inc.
// Registered output, one edge per increment; no backpressure.
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer for a variable-latency imem (req/ack); InstrF valid one edge after ack.
// Stalls the PC while a request is outstanding or decode is stalled; one-entry buffer in HOLD.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              PCSrcD,
  input  logic              StallD,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              StallF,
  output logic [DATA_W-1:0] InstrF,
  output logic              InstrValidF,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int WAIT_W = 16;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] buffer;
  logic              buf_valid;
  logic              pending;
  logic              ld_mem, ld_buf, kill, buf_set, buf_clr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;

  // PCF is only trusted in the issue cycle; later cycles replay the latched address.
  assign imem_addr = !imem_req ? '0 :
                     ((state == FETCH) && !pending) ? PCF : addr_q;
  assign wait_inc  = imem_req && !imem_ack;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    StallF    = 1'b1;
    ld_mem    = 1'b0;
    ld_buf    = 1'b0;
    kill      = 1'b0;
    buf_set   = 1'b0;
    buf_clr   = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (PCSrcD) begin
            StallF = 1'b0;
            kill   = 1'b1;
          end else if (StallD) begin
            buf_set   = 1'b1;
            state_nxt = HOLD;
          end else begin
            StallF = 1'b0;
            ld_mem = 1'b1;
          end
        end else if (PCSrcD) begin
          StallF    = 1'b0;
          kill      = 1'b1;
          state_nxt = SQUASH;
        end else if (!StallD) begin
          kill = 1'b1;
        end
      end
      SQUASH: begin
        // Drain the wrong-path request; its data is never forwarded.
        imem_req = 1'b1;
        if (PCSrcD)   StallF    = 1'b0;
        if (!StallD)  kill      = 1'b1;
        if (imem_ack) state_nxt = FETCH;
      end
      HOLD: begin
        if (PCSrcD) begin
          buf_clr   = 1'b1;
          StallF    = 1'b0;
          kill      = 1'b1;
          state_nxt = FETCH;
        end else if (!StallD && buf_valid) begin
          ld_buf    = 1'b1;
          buf_clr   = 1'b1;
          StallF    = 1'b0;
          state_nxt = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      pending     <= 1'b0;
      buffer      <= '0;
      buf_valid   <= 1'b0;
      InstrF      <= DATA_W'(NOP_INSTR);
      InstrValidF <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= (state == FETCH) && !imem_ack;
      if ((state == FETCH) && !pending) addr_q <= PCF;
      if (buf_set) buffer <= imem_rdata;
      if (buf_set) begin
        buf_valid <= 1'b1;
      end else if (buf_clr) begin
        buf_valid <= 1'b0;
      end
      if (ld_mem) begin
        InstrF      <= imem_rdata;
        InstrValidF <= 1'b1;
      end else if (ld_buf) begin
        InstrF      <= buffer;
        InstrValidF <= 1'b1;
      end else if (kill) begin
        InstrValidF <= 1'b0;
      end
    end
  end

  // Flags on the same edge that wait_cnt reaches TIMEOUT; request stays up.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      timeout_err <= 1'b0;
    end else if (wait_inc && (wait_cnt >= WAIT_W'(TIMEOUT - 1))) begin
      timeout_err <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (WAIT_W'(TIMEOUT))
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (Reset),
    .inc   (wait_inc),
    .clr   (imem_ack),
    .cnt   (wait_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (Reset),
    .inc   (StallF),
    .clr   (1'b0),
    .cnt   (stall_cycles)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: wait-state memory model, PC register model, instruction scoreboard.
module tb_fetch_sequencer;

  logic        clk;
  logic        Reset;
  logic [31:0] PCF;
  logic        PCSrcD;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        StallF;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        timeout_err;
  logic [3:0]  stall_cycles;

  logic [31:0] target;
  logic        nack;
  int          wait_states;
  int          wcnt;
  logic        squashing;
  logic [31:0] sb_q[$];
  int          n_tests;
  int          n_fail;

  fetch_sequencer #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .PCF          (PCF),
    .PCSrcD       (PCSrcD),
    .StallD       (StallD),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .StallF       (StallF),
    .InstrF       (InstrF),
    .InstrValidF  (InstrValidF),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory: ack after wait_states unacked request cycles, data derived from address.
  assign imem_ack   = imem_req && !nack && (wcnt >= wait_states);
  assign imem_rdata = mem_data(imem_addr);

  always @(posedge clk or negedge Reset) begin
    if (!Reset)                      wcnt <= 0;
    else if (imem_req && !imem_ack)  wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  // Scoreboard: decode consumes InstrF whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (Reset) begin
      if (InstrValidF && !StallD) begin
        if (sb_q.size() == 0) check("sb_underflow", InstrValidF, 0);
        else                  check("sb_instr", InstrF, sb_q.pop_front());
      end
      if (imem_req && imem_ack) begin
        if (!PCSrcD && !squashing) sb_q.push_back(imem_rdata);
        squashing = 1'b0;
      end else if (imem_req && PCSrcD) begin
        squashing = 1'b1;
      end
    end
  end

  // PC register model: loads on the edge when StallF was low.
  task automatic tick();
    logic sf, ps;
    sf = StallF;
    ps = PCSrcD;
    @(posedge clk);
    #1;
    if (!sf) PCF = ps ? target : PCF + 32'd4;
    PCSrcD = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; squashing = 1'b0;
    Reset = 1'b0; PCF = '0; PCSrcD = 1'b0; StallD = 1'b0;
    target = '0; nack = 1'b0; wait_states = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_stallf", StallF, 1);
    check("rst_valid", InstrValidF, 0);
    check("rst_instr", InstrF, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_scnt", stall_cycles, 0);
    Reset = 1'b1;

    // Zero-wait memory streaming
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("idle_req", imem_req, 0);
        check("idle_stallf", StallF, 1);
      end else begin
        check("zw_addr", imem_addr, 4 * (k - 1));
        check("zw_stallf", StallF, 0);
      end
      if (k >= 2) check("zw_valid", InstrValidF, 1);
      tick();
    end
    check("zw_stall_cycles", stall_cycles, 1);

    // Three wait states at 0x40
    PCF = 32'h40; wait_states = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ws_addr", imem_addr, 32'h40);
      check("ws_stallf", StallF, (i < 3) ? 1 : 0);
      if (i > 0) check("ws_bubble", InstrValidF, 0);
      tick();
    end
    check("ws_stall_cycles", stall_cycles, 4);

    // Redirect during a wait at 0x80
    PCF = 32'h80;
    @(negedge clk);
    check("sq_issue_addr", imem_addr, 32'h80);
    tick();
    PCSrcD = 1'b1; target = 32'h200;
    @(negedge clk);
    check("sq_redirect_stallf", StallF, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("sq_addr", imem_addr, 32'h80);
      check("sq_stallf", StallF, 1);
      check("sq_valid", InstrValidF, 0);
      tick();
    end
    wait_states = 0;
    @(negedge clk);
    check("sq_new_addr", imem_addr, 32'h200);
    check("sq_new_valid", InstrValidF, 0);
    tick();

    // Ack while decode stalled for two cycles
    PCF = 32'h300;
    @(negedge clk);
    check("hold_pre_addr", imem_addr, 32'h300);
    tick();
    StallD = 1'b1;
    @(negedge clk);
    check("hold_ack_addr", imem_addr, 32'h304);
    check("hold_ack_stallf", StallF, 1);
    tick();
    @(negedge clk);
    check("hold_req", imem_req, 0);
    check("hold_addr", imem_addr, 0);
    check("hold_stallf", StallF, 1);
    check("hold_instr", InstrF, mem_data(32'h300));
    check("hold_valid", InstrValidF, 1);
    tick();
    StallD = 1'b0;
    @(negedge clk);
    check("release_stallf", StallF, 0);
    tick();
    @(negedge clk);
    check("release_instr", InstrF, mem_data(32'h304));
    check("release_valid", InstrValidF, 1);
    check("release_addr", imem_addr, 32'h308);
    tick();

    // Redirect and stall together while holding
    PCF = 32'h400;
    @(negedge clk);
    tick();
    StallD = 1'b1;
    @(negedge clk);
    tick();
    PCSrcD = 1'b1; target = 32'h500;
    @(negedge clk);
    check("flush_stallf", StallF, 0);
    check("flush_req", imem_req, 0);
    tick();
    sb_q.delete();
    StallD = 1'b0;
    @(negedge clk);
    check("flush_addr", imem_addr, 32'h500);
    check("flush_valid", InstrValidF, 0);
    tick();

    // Timeout with ack held low
    nack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_no_err_yet", timeout_err, 0);
      check("to_addr", imem_addr, 32'h504);
      tick();
    end
    check("to_err_set", timeout_err, 1);
    check("to_stall_cycles", stall_cycles, 14);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("to_req_held", imem_req, 1);
      tick();
    end
    nack = 1'b0;
    @(negedge clk);
    check("to_ack_stallf", StallF, 0);
    tick();
    nack = 1'b1;
    @(negedge clk);
    tick();
    check("to_err_sticky", timeout_err, 1);
    check("sat_stall_cycles", stall_cycles, 15);
    check("sb_drained", sb_q.size(), 0);
    check("req_before_rst", imem_req, 1);

    // Asynchronous reset mid-request
    #1 Reset = 1'b0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_terr", timeout_err, 0);
    check("arst_scnt", stall_cycles, 0);
    check("arst_valid", InstrValidF, 0);
    #20 Reset = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the fetch stage against a variable-latency instruction memory using a req/ack handshake.
- Generates StallF for the PC pipeline register and holds the memory address stable while a request is outstanding.
- Squashes in-flight fetches when decode redirects (PCSrcD), and buffers one instruction while decode is stalled.
- Sits between the PC register/PC mux and the instruction memory; feeds InstrF/InstrValidF to the decode pipeline register.

Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction width.
- TIMEOUT, 255, cycles of unacknowledged req before timeout_err sets (1..65535).
- CNT_W, 16, width of stall_cycles perf counter.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- PCF  in  ADDR_W  current PC register value.
- PCSrcD  in  1  one-cycle redirect pulse from decode; PC mux selects PCBranchD this cycle.
- StallD  in  1  decode register stalled.
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  data valid; may be asserted combinationally in the same cycle as req.
- imem_rdata  in  DATA_W  instruction data, valid with ack.
- StallF  out  1  hold the PC register.
- InstrF  out  DATA_W  registered instruction to decode.
- InstrValidF  out  1  InstrF is valid (0 = bubble).
- timeout_err  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Reset (Reset=0, async): state=IDLE, imem_req=0, addr_q=0, InstrF=0, InstrValidF=0, StallF=1, buf_valid=0, wait_cnt=0, timeout_err=0, stall_cycles=0.
- States: IDLE, FETCH, SQUASH, HOLD.
- IDLE: StallF=1, imem_req=0. Goes to FETCH on the next edge.
- FETCH:
  - imem_req=1.
  - imem_addr = PCF on the first cycle of the request (issue cycle); addr_q is latched then. imem_addr = addr_q on every later cycle until ack.
  - ack & PCSrcD: data dropped, StallF=0 (PC loads branch target), InstrValidF<=0. Stay FETCH; the next cycle is a new issue.
  - ack & ~PCSrcD & ~StallD: InstrF<=imem_rdata, InstrValidF<=1, StallF=0 (PC advances). The next cycle is a new issue.
  - ack & StallD & ~PCSrcD: buffer<=imem_rdata, buf_valid<=1, StallF=1, InstrF/InstrValidF held. Go to HOLD.
  - ~ack & PCSrcD: StallF=0 (PC takes target), InstrValidF<=0. Go to SQUASH.
  - ~ack otherwise: StallF=1. If ~StallD, InstrValidF<=0 (bubble); else outputs held.
- SQUASH:
  - imem_req=1, imem_addr=addr_q, StallF=1, InstrValidF<=0 unless StallD.
  - On ack, data is discarded and state goes to FETCH (new issue from the redirected PCF).
  - A further PCSrcD in SQUASH: StallF=0 that cycle; remain in SQUASH.
- HOLD:
  - imem_req=0, StallF=1.
  - PCSrcD: buf_valid<=0, StallF=0, InstrValidF<=0, go to FETCH.
  - ~StallD: InstrF<=buffer, InstrValidF<=1, buf_valid<=0, StallF=0, go to FETCH.
  - Otherwise hold.
- Priority: PCSrcD over StallD over ack-forwarding.
- Latency: with zero-wait memory (ack in the issue cycle), one instruction per cycle; InstrF is valid one edge after ack.
- wait_cnt:
  - Increments each cycle imem_req=1 & ~imem_ack; clears on ack.
  - When wait_cnt reaches TIMEOUT, timeout_err<=1, sticky until Reset. The request remains asserted (no abort).
  - wait_cnt saturates at TIMEOUT.
- stall_cycles: +1 each cycle StallF=1; saturates at 2^CNT_W-1, never wraps.
- Reset asserted mid-request drops req asynchronously. The memory must tolerate an abandoned request.
- imem_addr is 0 whenever imem_req=0.

Decomposition:
- Shared package fetch_pkg:
  - State enum (IDLE, FETCH, SQUASH, HOLD).
  - Defaults for ADDR_W and DATA_W.
  - NOP instruction constant 32'h00000000, used as InstrF content for documentation and checkers.
- One sub-module: sat_counter (parameter WIDTH; inputs inc and clr; saturating at all-ones, or at MAX when given). Instantiated for wait_cnt and stall_cycles.

Test Plan:
- Reset release, zero-wait memory (ack=req), PCF stepping by 4 from 0 -> IDLE one cycle, then InstrF tracks rdata each cycle, InstrValidF=1 continuously, StallF=0 after the first issue, stall_cycles=1.
- 3-wait-state memory -> imem_addr stable at 0x40 for all 4 req cycles, StallF=1 for 3 cycles, InstrValidF=0 bubbles, stall_cycles increments by 3.
- PCSrcD pulse during a wait at addr 0x80 (target 0x200) -> StallF=0 that cycle; SQUASH holds imem_addr=0x80 until ack; that data is never valid; next issue addr=0x200.
- Ack while StallD=1 for 2 cycles -> data buffered, StallF=1, InstrF unchanged; on StallD fall, InstrF=buffered word with InstrValidF=1 and StallF=0.
- PCSrcD and StallD together in HOLD -> buffer discarded, InstrValidF=0, next issue at the redirected PCF.
- ack held low with TIMEOUT=4 -> timeout_err=1 after the 4th unacked cycle, remains 1 after a later ack; Reset low clears it asynchronously.
